// File: rtl/jtag_uart_rx_reader.sv
// JTAG UART receive reader: polls the JTAG UART data register over Avalon-MM,
// keeps only characters flagged RVALID, and hands them to the core through a
// small FIFO exposed as a valid/ready byte stream.
module jtag_uart_rx_reader #(
    parameter int FIFO_DEPTH = 16,
    parameter int POLL_DIV   = 64,
    parameter int CNT_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    output logic                        av_chipselect,
    output logic                        av_address,
    output logic                        av_read_n,
    output logic                        av_write_n,
    input  logic [31:0]                 av_readdata,
    input  logic                        av_waitrequest,
    output logic [7:0]                  rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [CNT_W-1:0]            rx_count,
    output logic                        host_pending
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
    localparam logic [TW-1:0] TMAX    = TW'(POLL_DIV - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [AW:0]     rd_ptr_q, wr_ptr_q;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [7:0]      cap_char_q;
    logic            cap_vld_q;
    logic            cap_avail_q;
    logic [CNT_W-1:0] cnt_q;
    logic            hp_q;

    logic            push;
    logic            pop;
    logic            timer_sat;
    logic [LW-1:0]   level_after;
    logic            unused_rsvd;

    // Character bits 14:8 of the data register carry nothing we need.
    assign unused_rsvd = ^av_readdata[14:8];

    assign timer_sat   = (timer_q == TMAX);
    assign fifo_level  = wr_ptr_q - rd_ptr_q;
    assign rx_valid    = (wr_ptr_q != rd_ptr_q);
    assign rx_data     = rx_valid ? mem_q[rd_ptr_q[AW-1:0]] : 8'h00;
    assign push        = (state_q == CAPTURE) && cap_vld_q;
    assign pop         = rx_valid && rx_ready;
    assign level_after = fifo_level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

    // Bus strobes decode straight from the state register so reset drops them at once.
    assign av_chipselect = (state_q == READ);
    assign av_read_n     = (state_q != READ);
    assign av_address    = 1'b0;
    assign av_write_n    = 1'b1;
    assign rx_count      = cnt_q;
    assign host_pending  = hp_q;

    // Next-state logic: poll when the timer saturates, drain back-to-back while the host has more.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            IDLE: begin
                if (timer_sat && (fifo_level < DEPTH_L)) begin
                    state_d = READ;
                    timer_d = '0;
                end else if (!timer_sat) begin
                    timer_d = timer_q + TW'(1);
                end
            end
            READ: begin
                if (!av_waitrequest) state_d = CAPTURE;
            end
            CAPTURE: begin
                if (cap_vld_q && cap_avail_q && (level_after < DEPTH_L)) state_d = READ;
                else state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and poll timer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Capture the fields of interest on the cycle the read completes.
    always_ff @(posedge clk) begin
        if ((state_q == READ) && !av_waitrequest) begin
            cap_char_q  <= av_readdata[7:0];
            cap_vld_q   <= av_readdata[15];
            cap_avail_q <= (av_readdata[31:16] != 16'h0000);
        end
    end

    // FIFO storage; occupancy is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= cap_char_q;
    end

    // FIFO pointers with an extra wrap bit to tell full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + LW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + LW'(1);
        end
    end

    // Received-byte counter and host-pending flag, both updated from the capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            hp_q  <= 1'b0;
        end else if (state_q == CAPTURE) begin
            hp_q <= cap_avail_q;
            if (cap_vld_q) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_jtag_uart_rx_reader.sv
// Bench for jtag_uart_rx_reader: emulates the JTAG UART IP data register and a
// consumer, and predicts the byte stream, occupancy, count and pending flag.
module tb_jtag_uart_rx_reader;

    localparam int DEPTH = 4;
    localparam int PDIV  = 4;
    localparam int CW    = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        av_chipselect, av_address, av_read_n, av_write_n;
    logic [31:0] av_readdata;
    logic        av_waitrequest;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [$clog2(DEPTH):0] fifo_level;
    logic [CW-1:0] rx_count;
    logic        host_pending;

    jtag_uart_rx_reader #(.FIFO_DEPTH(DEPTH), .POLL_DIV(PDIV), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .av_chipselect(av_chipselect), .av_address(av_address),
        .av_read_n(av_read_n), .av_write_n(av_write_n),
        .av_readdata(av_readdata), .av_waitrequest(av_waitrequest),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .fifo_level(fifo_level), .rx_count(rx_count), .host_pending(host_pending)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: expected FIFO contents and counters, plus the IP's queue.
    logic [7:0]  exp_q [$];
    logic [31:0] ip_q  [$];
    logic [31:0] idle_word = 32'h0;
    int          exp_cnt = 0;
    logic        exp_hp = 1'b0;
    logic        cap_pend = 1'b0;
    logic [31:0] cap_w = 32'h0;
    logic        prev_stall = 1'b0;
    int          reads_done = 0;
    int          n_pops = 0;
    int          cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic upd_rd();
        av_readdata = (ip_q.size() != 0) ? ip_q[0] : idle_word;
    endtask

    function automatic logic strobe_now();
        return av_chipselect && !av_read_n;
    endfunction

    // One clock of bus/consumer observation and model update; called mid-cycle.
    task automatic tick();
        logic strobe, rd_fire, pop_fire;
        strobe   = strobe_now();
        rd_fire  = strobe && !av_waitrequest;
        pop_fire = rx_valid && rx_ready;
        if (prev_stall)
            chk("strobe_held", {29'd0, av_chipselect, av_read_n, av_address}, 32'h4);
        if (strobe) begin
            chk("read_only_with_space", 32'(exp_q.size() < DEPTH), 32'h1);
            chk("write_n_high", 32'(av_write_n), 32'h1);
        end
        if (pop_fire && exp_q.size() != 0) chk("rx_data", 32'(rx_data), 32'(exp_q[0]));
        prev_stall = strobe && av_waitrequest;
        @(posedge clk);
        if (pop_fire && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            n_pops++;
        end
        if (cap_pend) begin
            exp_hp = (cap_w[31:16] != 16'h0);
            if (cap_w[15]) begin
                exp_q.push_back(cap_w[7:0]);
                exp_cnt = (exp_cnt + 1) % (1 << CW);
            end
        end
        cap_pend = rd_fire;
        if (rd_fire) begin
            cap_w = av_readdata;
            reads_done++;
            if (ip_q.size() != 0) void'(ip_q.pop_front());
        end
        cyc++;
        @(negedge clk);
        upd_rd();
        chk("fifo_level", 32'(fifo_level), 32'(exp_q.size()));
        chk("rx_valid", 32'(rx_valid), 32'(exp_q.size() != 0));
        chk("rx_count", 32'(rx_count), 32'(exp_cnt));
        chk("host_pending", 32'(host_pending), 32'(exp_hp));
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_cnt    = 0;
        exp_hp     = 1'b0;
        cap_pend   = 1'b0;
        prev_stall = 1'b0;
        cyc        = 0;
    endtask

    initial begin
        int last, nlow, r0, found;
        int s [$];

        rst_n = 1'b0;
        rx_ready = 1'b0;
        av_waitrequest = 1'b0;
        upd_rd();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_chipselect", 32'(av_chipselect), 32'h0);
        chk("rst_read_n", 32'(av_read_n), 32'h1);
        chk("rst_write_n", 32'(av_write_n), 32'h1);
        chk("rst_address", 32'(av_address), 32'h0);
        chk("rst_rx_valid", 32'(rx_valid), 32'h0);
        chk("rst_rx_data", 32'(rx_data), 32'h0);
        chk("rst_level", 32'(fifo_level), 32'h0);
        chk("rst_count", 32'(rx_count), 32'h0);
        chk("rst_pending", 32'(host_pending), 32'h0);
        rst_n = 1'b1;
        model_reset();

        // Empty host: one single-cycle read every POLL_DIV+2 cycles, first after POLL_DIV idle cycles.
        last = -1;
        nlow = 0;
        for (int i = 0; i < 30; i++) begin
            if (strobe_now()) begin
                if (last < 0) chk("first_poll_cycle", 32'(cyc), 32'(PDIV));
                else chk("poll_gap", 32'(cyc - last), 32'(PDIV + 2));
                last = cyc;
                nlow++;
            end
            tick();
        end
        chk("poll_count", 32'(nlow), 32'd5);
        chk("empty_no_valid", 32'(rx_valid), 32'h0);

        // Burst drain while RAVAIL is nonzero.
        rx_ready = 1'b1;
        ip_q = '{32'h0002_8041, 32'h0001_8042, 32'h0000_8043};
        upd_rd();
        r0 = n_pops;
        for (int i = 0; i < 14; i++) begin
            if (strobe_now() && s.size() < 3) s.push_back(cyc);
            tick();
        end
        chk("burst_reads", 32'(s.size()), 32'd3);
        if (s.size() == 3) begin
            chk("burst_gap1", 32'(s[1] - s[0]), 32'd2);
            chk("burst_gap2", 32'(s[2] - s[1]), 32'd2);
        end
        chk("burst_bytes_out", 32'(n_pops - r0), 32'd3);
        chk("burst_count", 32'(rx_count), 32'd3);
        chk("burst_pending_end", 32'(host_pending), 32'h0);

        // Waitrequest stall of 5 cycles during a read.
        av_waitrequest = 1'b1;
        ip_q = '{32'h0000_8077};
        upd_rd();
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (strobe_now()) found = 1;
            else tick();
        end
        chk("stall_read_seen", 32'(found), 32'h1);
        for (int k = 0; k < 5; k++) begin
            chk("stall_strobes", {29'd0, av_chipselect, av_read_n, av_address}, 32'h4);
            tick();
        end
        av_waitrequest = 1'b0;
        r0 = reads_done;
        repeat (4) tick();
        chk("stall_one_read", 32'(reads_done - r0), 32'd1);
        chk("stall_count", 32'(rx_count), 32'd4);

        // Full FIFO: reads stop at DEPTH and resume after one pop.
        rx_ready = 1'b0;
        idle_word = 32'h0010_8055;
        upd_rd();
        r0 = reads_done;
        repeat (20) tick();
        nlow = 0;
        for (int i = 0; i < 20; i++) begin
            if (strobe_now()) nlow++;
            tick();
        end
        chk("full_reads", 32'(reads_done - r0), 32'(DEPTH));
        chk("full_level", 32'(fifo_level), 32'(DEPTH));
        chk("full_no_strobe", 32'(nlow), 32'd0);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        chk("pulse_level", 32'(fifo_level), 32'(DEPTH - 1));
        r0 = reads_done;
        repeat (12) tick();
        chk("refill_level", 32'(fifo_level), 32'(DEPTH));
        chk("refill_reads", 32'(reads_done - r0), 32'd1);

        // Push and pop in the same capture cycle near full.
        idle_word = 32'h0;
        ip_q = '{32'h0000_80A1};
        upd_rd();
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (strobe_now()) found = 1;
            else tick();
        end
        chk("pp_read_seen", 32'(found), 32'h1);
        tick();
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        chk("pp_level", 32'(fifo_level), 32'(DEPTH - 1));
        rx_ready = 1'b1;
        repeat (10) tick();
        chk("pp_drained", 32'(fifo_level), 32'h0);

        // Reset while a read is stalled.
        av_waitrequest = 1'b1;
        ip_q = '{32'h0000_80EE};
        upd_rd();
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (strobe_now()) found = 1;
            else tick();
        end
        chk("rst_mid_read_seen", 32'(found), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_read_n", 32'(av_read_n), 32'h1);
        chk("rst_mid_chipselect", 32'(av_chipselect), 32'h0);
        @(negedge clk);
        @(negedge clk);
        av_waitrequest = 1'b0;
        rst_n = 1'b1;
        model_reset();
        chk("rst_mid_level", 32'(fifo_level), 32'h0);
        chk("rst_mid_count", 32'(rx_count), 32'h0);

        // Randomised traffic: random words, stalls and consumer back-pressure.
        ip_q.delete();
        for (int i = 0; i < 300; i++) begin
            ip_q.push_back({(($urandom % 3) == 0) ? 16'h0 : 16'($urandom_range(1, 8)),
                            1'(($urandom % 4) != 0), 7'h0, 8'($urandom)});
        end
        upd_rd();
        for (int i = 0; i < 2500; i++) begin
            av_waitrequest = (($urandom % 10) < 3);
            rx_ready = 1'($urandom % 2);
            tick();
        end
        av_waitrequest = 1'b0;
        rx_ready = 1'b1;
        for (int i = 0; i < 2000 && ip_q.size() != 0; i++) tick();
        repeat (20) tick();
        chk("rand_ip_drained", 32'(ip_q.size()), 32'h0);
        chk("rand_fifo_empty", 32'(fifo_level), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
